// File: rtl/sys_seq.sv
// Staggered domain-reset sequencer with a free-running cycle counter and a
// bank of request/grant cycle timers, all in the single system clock domain.
module sys_seq #(
    parameter int NUM_DOMAINS       = 4,
    parameter int RESET_CYCLES      = 25,
    parameter int STAGGER_CYCLES    = 8,
    parameter int POST_RESET_CYCLES = 100,
    parameter int NUM_TIMERS        = 4,
    parameter int TIMER_WIDTH       = 16,
    parameter int COUNTER_WIDTH     = 31,
    localparam int ID_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start,
    output logic [NUM_DOMAINS-1:0]   DomRst_n,
    output logic                     Ready,
    output logic [COUNTER_WIDTH-1:0] CycleCounter,
    input  logic                     TmrReq,
    input  logic [TIMER_WIDTH-1:0]   TmrCycles,
    output logic                     TmrGnt,
    output logic [ID_W-1:0]          TmrId,
    output logic                     TmrOvf,
    output logic [NUM_TIMERS-1:0]    TmrDone
);

    localparam int PH_MAX0 = (RESET_CYCLES > STAGGER_CYCLES) ? RESET_CYCLES : STAGGER_CYCLES;
    localparam int PH_MAX  = (PH_MAX0 > POST_RESET_CYCLES) ? PH_MAX0 : POST_RESET_CYCLES;
    localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int DOM_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [PH_W-1:0]  RES_LAST  = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0]  STG_LAST  = PH_W'(STAGGER_CYCLES - 1);
    localparam logic [PH_W-1:0]  POST_LAST = PH_W'(POST_RESET_CYCLES - 1);
    localparam logic [DOM_W-1:0] DOM_LAST  = DOM_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_POST,
        S_READY
    } state_t;

    state_t                 state;
    logic [PH_W-1:0]        phase;
    logic [DOM_W-1:0]       rel_idx;
    logic [NUM_DOMAINS-1:0] rel_mask;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            CycleCounter <= '0;
        end else begin
            CycleCounter <= CycleCounter + COUNTER_WIDTH'(1);
        end
    end

    always_comb begin
        rel_mask = DomRst_n;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            if (DOM_W'(i) == rel_idx) begin
                rel_mask[i] = 1'b1;
            end
        end
    end

    // Outputs are registered one edge ahead of the phase count, so each
    // release/Ready lands exactly in its target cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_HOLD;
            phase    <= '0;
            rel_idx  <= '0;
            DomRst_n <= '0;
            Ready    <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (phase == RES_LAST) begin
                        phase <= '0;
                        if (STAGGER_CYCLES == 0 || NUM_DOMAINS == 1) begin
                            DomRst_n <= '1;
                            if (POST_RESET_CYCLES == 0) begin
                                Ready <= 1'b1;
                                state <= S_READY;
                            end else begin
                                state <= S_POST;
                            end
                        end else begin
                            DomRst_n <= rel_mask;
                            rel_idx  <= DOM_W'(1);
                            state    <= S_RELEASE;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (phase == STG_LAST) begin
                        phase    <= '0;
                        DomRst_n <= rel_mask;
                        if (rel_idx == DOM_LAST) begin
                            if (POST_RESET_CYCLES == 0) begin
                                Ready <= 1'b1;
                                state <= S_READY;
                            end else begin
                                state <= S_POST;
                            end
                        end else begin
                            rel_idx <= rel_idx + DOM_W'(1);
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_POST: begin
                    if (phase == POST_LAST) begin
                        phase <= '0;
                        Ready <= 1'b1;
                        state <= S_READY;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_READY: begin
                    if (Start) begin
                        DomRst_n <= '0;
                        Ready    <= 1'b0;
                        phase    <= '0;
                        rel_idx  <= '0;
                        state    <= S_HOLD;
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

    logic [NUM_TIMERS-1:0]  busy;
    logic [TIMER_WIDTH-1:0] cnt [NUM_TIMERS];
    logic                   any_free;

    always_comb begin
        any_free = 1'b0;
        TmrId    = '0;
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            if (!busy[i] && !any_free) begin
                any_free = 1'b1;
                TmrId    = ID_W'(i);
            end
        end
        TmrGnt = TmrReq & any_free;
    end

    // cnt holds cycles remaining before the done edge; a 1-cycle wait pulses
    // straight from the grant edge without ever marking the slot busy.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy    <= '0;
            TmrDone <= '0;
            TmrOvf  <= 1'b0;
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            TmrOvf <= TmrReq & ~any_free;
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                TmrDone[i] <= 1'b0;
                if (busy[i]) begin
                    if (cnt[i] == TIMER_WIDTH'(1)) begin
                        busy[i]    <= 1'b0;
                        TmrDone[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] - TIMER_WIDTH'(1);
                    end
                end else if (TmrGnt && TmrId == ID_W'(i)) begin
                    if (TmrCycles <= TIMER_WIDTH'(1)) begin
                        TmrDone[i] <= 1'b1;
                    end else begin
                        busy[i] <= 1'b1;
                        cnt[i]  <= TmrCycles - TIMER_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sys_seq.sv
// Directed bench for sys_seq: default sequencing, restart, timer bank,
// mid-sequence reset, and a minimal single-domain configuration.
module tb_sys_seq;

    logic        clk = 1'b0;
    logic        rst, rst2, start, req;
    logic [15:0] tcyc;
    logic [3:0]  dom, done;
    logic        ready, gnt, ovf;
    logic [30:0] ccnt;
    logic [1:0]  tid;

    logic [0:0]  dom2;
    logic        ready2, gnt2, ovf2;
    logic [3:0]  ccnt2, done2;
    logic [1:0]  tid2;

    int          cyc, base, tests, fails;
    logic [3:0]  done_seen;

    always #5 clk = ~clk;

    sys_seq dut (
        .Clk(clk), .Rst(rst), .Start(start), .DomRst_n(dom), .Ready(ready),
        .CycleCounter(ccnt), .TmrReq(req), .TmrCycles(tcyc), .TmrGnt(gnt),
        .TmrId(tid), .TmrOvf(ovf), .TmrDone(done)
    );

    sys_seq #(
        .NUM_DOMAINS(1), .STAGGER_CYCLES(0), .POST_RESET_CYCLES(0), .COUNTER_WIDTH(4)
    ) dut2 (
        .Clk(clk), .Rst(rst2), .Start(1'b0), .DomRst_n(dom2), .Ready(ready2),
        .CycleCounter(ccnt2), .TmrReq(1'b0), .TmrCycles(16'd0), .TmrGnt(gnt2),
        .TmrId(tid2), .TmrOvf(ovf2), .TmrDone(done2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        done_seen |= done;
    endtask

    task automatic adv(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0; fails = 0; done_seen = '0;
        rst = 1'b1; rst2 = 1'b1; start = 1'b0; req = 1'b0; tcyc = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst2 = 1'b0; cyc = 0;

        chk("reset_dom", 64'(dom), 64'h0);
        chk("reset_ready", 64'(ready), 64'h0);
        chk("reset_ccnt", 64'(ccnt), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_ovf", 64'(ovf), 64'h0);

        adv(15); chk("small_ccnt15", 64'(ccnt2), 64'd15);
        adv(16); chk("small_ccnt_wrap", 64'(ccnt2), 64'd0);
        adv(24);
        chk("dom_c24", 64'(dom), 64'h0);
        chk("small_dom_c24", 64'(dom2), 64'h0);
        chk("small_ready_c24", 64'(ready2), 64'h0);
        adv(25);
        chk("dom_c25", 64'(dom), 64'h1);
        chk("small_dom_c25", 64'(dom2), 64'h1);
        chk("small_ready_c25", 64'(ready2), 64'h1);
        adv(32); chk("dom_c32", 64'(dom), 64'h1);
        adv(33); chk("dom_c33", 64'(dom), 64'h3);
        adv(40); chk("dom_c40", 64'(dom), 64'h3);
        adv(41); chk("dom_c41", 64'(dom), 64'h7);
        adv(48); chk("dom_c48", 64'(dom), 64'h7);
        adv(49); chk("dom_c49", 64'(dom), 64'hf);
        adv(60); start = 1'b1;
        adv(61); start = 1'b0;
        chk("post_start_ignored_dom", 64'(dom), 64'hf);
        adv(148); chk("ready_c148", 64'(ready), 64'h0);
        adv(149);
        chk("ready_c149", 64'(ready), 64'h1);
        chk("ccnt_c149", 64'(ccnt), 64'd149);

        adv(152); start = 1'b1;
        tick(); start = 1'b0;
        base = cyc;
        chk("restart_dom", 64'(dom), 64'h0);
        chk("restart_ready", 64'(ready), 64'h0);
        chk("restart_ccnt", 64'(ccnt), 64'd153);
        adv(base + 24); chk("rs_dom_24", 64'(dom), 64'h0);
        adv(base + 25); chk("rs_dom_25", 64'(dom), 64'h1);
        adv(base + 33); chk("rs_dom_33", 64'(dom), 64'h3);
        adv(base + 41); chk("rs_dom_41", 64'(dom), 64'h7);
        adv(base + 49); chk("rs_dom_49", 64'(dom), 64'hf);
        adv(base + 148); chk("rs_ready_148", 64'(ready), 64'h0);
        adv(base + 149);
        chk("rs_ready_149", 64'(ready), 64'h1);
        chk("rs_ccnt_149", 64'(ccnt), 64'd302);

        // Single timer, length 5: granted in 303, done only in 308.
        tick();
        req = 1'b1; tcyc = 16'd5; #1;
        chk("t5_gnt", 64'(gnt), 64'h1);
        chk("t5_id", 64'(tid), 64'h0);
        tick(); req = 1'b0; done_seen = '0;
        adv(307); chk("t5_no_early_done", 64'(done_seen), 64'h0);
        adv(308); chk("t5_done", 64'(done), 64'h1);
        adv(309); chk("t5_done_clear", 64'(done), 64'h0);

        // Zero length behaves as one cycle.
        req = 1'b1; tcyc = 16'd0; #1;
        chk("t0_gnt", 64'(gnt), 64'h1);
        tick(); req = 1'b0;
        chk("t0_done", 64'(done), 64'h1);
        tick(); chk("t0_done_clear", 64'(done), 64'h0);

        // Fill all four slots (311..314), overflow at 315.
        for (int k = 0; k < 4; k++) begin
            req = 1'b1; tcyc = 16'd10; #1;
            chk("fill_gnt", 64'(gnt), 64'h1);
            chk("fill_id", 64'(tid), 64'(k));
            tick();
        end
        #1;
        chk("full_gnt", 64'(gnt), 64'h0);
        chk("full_id", 64'(tid), 64'h0);
        tick(); req = 1'b0;
        chk("ovf_pulse", 64'(ovf), 64'h1);
        tick(); chk("ovf_clear", 64'(ovf), 64'h0);
        adv(320); chk("slot0_not_done_320", 64'(done), 64'h0);
        adv(321);
        req = 1'b1; tcyc = 16'd10; #1;
        chk("slot0_done_321", 64'(done), 64'h1);
        chk("regrant_gnt", 64'(gnt), 64'h1);
        chk("regrant_id", 64'(tid), 64'h0);
        tick(); req = 1'b0;
        chk("slot1_done", 64'(done), 64'h2);
        tick(); chk("slot2_done", 64'(done), 64'h4);
        tick(); chk("slot3_done", 64'(done), 64'h8);

        // Reset during RELEASE with two timers busy.
        adv(340); start = 1'b1;
        tick(); start = 1'b0;
        base = cyc;
        adv(base + 28);
        req = 1'b1; tcyc = 16'd20; #1;
        chk("rr_gnt0", 64'(tid), 64'h0);
        tick(); #1;
        chk("rr_gnt1", 64'(tid), 64'h1);
        tick(); req = 1'b0;
        adv(base + 31);
        chk("rr_dom_release", 64'(dom), 64'h1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        cyc = 0; done_seen = '0;
        chk("rr_dom", 64'(dom), 64'h0);
        chk("rr_ready", 64'(ready), 64'h0);
        chk("rr_ccnt", 64'(ccnt), 64'h0);
        chk("rr_done", 64'(done), 64'h0);
        chk("rr_ovf", 64'(ovf), 64'h0);
        adv(24); chk("rr_dom_24", 64'(dom), 64'h0);
        adv(25); chk("rr_dom_25", 64'(dom), 64'h1);
        adv(60); chk("rr_no_done", 64'(done_seen), 64'h0);
        req = 1'b1; tcyc = 16'd3; #1;
        chk("rr_free_gnt", 64'(gnt), 64'h1);
        chk("rr_free_id", 64'(tid), 64'h0);
        tick(); req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sys_seq.md
Name: sys_seq

Overview:
- Synthesizable, parametrised clock-domain reset sequencer with a bank of concurrent cycle timers.
- Runs in the single system clock domain. After reset it releases NUM_DOMAINS active-low domain resets in a staggered order, then raises Ready after a post-reset settle period.
- Provides a free-running cycle counter and NUM_TIMERS hardware wait slots that on-chip controllers allocate through a request/grant handshake.

Parameters:
- NUM_DOMAINS, 4: number of sequenced domain resets (1..16).
- RESET_CYCLES, 25: cycles all domains are held in reset (>=1).
- STAGGER_CYCLES, 8: cycles between consecutive domain releases (>=0).
- POST_RESET_CYCLES, 100: cycles from last domain release to Ready (>=0).
- NUM_TIMERS, 4: number of concurrent wait slots (1..32).
- TIMER_WIDTH, 16: width of timer cycle count.
- COUNTER_WIDTH, 31: width of CycleCounter.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Start  input  1  one-cycle pulse; re-runs the reset sequence (honoured only while Ready=1).
- DomRst_n  output  NUM_DOMAINS  per-domain reset, active low, bit k = domain k.
- Ready  output  1  high once the sequence has completed.
- CycleCounter  output  COUNTER_WIDTH  free-running cycle count.
- TmrReq  input  1  timer allocation request.
- TmrCycles  input  TIMER_WIDTH  requested wait length in cycles.
- TmrGnt  output  1  combinational grant, = TmrReq & (any slot free).
- TmrId  output  clog2(NUM_TIMERS) (min 1)  index of granted slot (lowest free index); 0 when no slot is free.
- TmrOvf  output  1  registered one-cycle pulse: TmrReq seen with no free slot.
- TmrDone  output  NUM_TIMERS  registered one-cycle completion pulse per slot.

Behaviour:
- Reset values while Rst=1 (sampled on Clk):
  - DomRst_n=0, Ready=0, CycleCounter=0, TmrDone=0, TmrOvf=0.
  - All slots free, FSM in HOLD, phase counter=0.
- CycleCounter: +1 every cycle Rst=0; wraps to 0 at all-ones; unaffected by Start.
- FSM states: HOLD, RELEASE, POST, READY. Cycle 0 is the first cycle after Rst deasserts, or the first cycle after Start is sampled in READY.
- HOLD: all DomRst_n=0 for cycles 0..RESET_CYCLES-1, then go to RELEASE.
- RELEASE:
  - Domain k's DomRst_n rises in cycle RESET_CYCLES + k*STAGGER_CYCLES, stays high, and never deasserts out of order.
  - STAGGER_CYCLES=0 releases all domains in cycle RESET_CYCLES.
  - Go to POST after domain NUM_DOMAINS-1 is released.
- POST: Ready rises in cycle RESET_CYCLES + (NUM_DOMAINS-1)*STAGGER_CYCLES + POST_RESET_CYCLES. POST_RESET_CYCLES=0 raises Ready in the same cycle as the last release.
- READY:
  - Start=1 sampled: next cycle DomRst_n=all 0, Ready=0, state=HOLD, sequence restarts at cycle 0.
  - Start in any other state is ignored.
- Single phase counter, width sized for the longest phase; cleared on each state change.
- Timer slots, each with busy flag and TIMER_WIDTH count:
  - Grant, when TmrGnt=1 at an edge: slot TmrId gets busy<=1, cnt<=max(TmrCycles,1).
  - Each edge while busy: cnt<=cnt-1. When cnt==1: busy<=0 and TmrDone[id]<=1 for exactly one cycle.
  - A grant sampled in cycle t gives TmrDone high in cycle t+N (N=max(TmrCycles,1)).
  - A slot is free again in its TmrDone cycle and may be re-granted that same cycle.
- No free slot: TmrGnt=0, TmrId=0; TmrOvf=1 in the next cycle for each such request cycle. Requests are not queued.
- Timers run independently of the FSM: they are not cleared by Start and count during HOLD. Only Rst clears them.
- Multiple slots may pulse TmrDone in the same cycle.
- Rst asserted mid-sequence or mid-timer: all state returns to reset values at that edge.

Test Plan:
- Defaults; Rst high 3 cycles then low → DomRst_n bits 0..3 rise in cycles 25, 33, 41, 49; Ready rises in cycle 149; CycleCounter=149 in that cycle.
- Ready=1, pulse Start → DomRst_n=0 and Ready=0 next cycle; releases at 25/33/41/49 relative to restart; CycleCounter keeps counting. Start pulsed during POST has no effect.
- TmrReq with TmrCycles=5 in cycle t → TmrGnt=1, TmrId=0; TmrDone[0] high only in cycle t+5. TmrCycles=0 → TmrDone in cycle t+1.
- Four requests in consecutive cycles, TmrCycles=10 → TmrId 0, 1, 2, 3. Fifth request → TmrGnt=0, TmrOvf=1 next cycle. Request in the cycle slot 0's TmrDone pulses → granted TmrId=0.
- Rst asserted in RELEASE with 2 timers busy → all outputs at reset values next cycle; no TmrDone pulses afterwards; sequence restarts from cycle 0.
- NUM_DOMAINS=1, STAGGER_CYCLES=0, POST_RESET_CYCLES=0, COUNTER_WIDTH=4 → DomRst_n and Ready rise together in cycle 25; CycleCounter wraps 15→0.
